// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/DE/blanking generator.
//   clk, rst        sole clock, synchronous active-high reset
//   en              run enable; low freezes divider, counters, pipeline, outputs
//   pixel_in        pixel for the position requested PIX_LAT ticks earlier
//   pos_x, pos_y    requested position (raw counters)
//   req             requested position is visible (and block running)
//   pixel_out, hsync, vsync, de        registered outputs to the DAC/pins
//   frame_start, line_start            one-clk pulses with (0,0) / x=0 on outputs
module vga_timing_gen #(
  parameter int                 H_ACTIVE    = 640,
  parameter int                 H_FP        = 16,
  parameter int                 H_SYNC      = 96,
  parameter int                 H_BP        = 48,
  parameter int                 V_ACTIVE    = 480,
  parameter int                 V_FP        = 10,
  parameter int                 V_SYNC      = 2,
  parameter int                 V_BP        = 33,
  parameter logic               HS_POL      = 1'b0,
  parameter logic               VS_POL      = 1'b0,
  parameter int                 COLOR_W     = 12,
  parameter logic [COLOR_W-1:0] BLANK_COLOR = '0,
  parameter int                 PIX_LAT     = 1,
  parameter int                 CLK_DIV     = 1,
  localparam int                H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int                V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int                XW          = $clog2(H_TOTAL),
  localparam int                YW          = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COLOR_W-1:0] pixel_in,
  output logic [XW-1:0]      pos_x,
  output logic [YW-1:0]      pos_y,
  output logic               req,
  output logic [COLOR_W-1:0] pixel_out,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               frame_start,
  output logic               line_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_HS0  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] X_HS1  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_VS0  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] Y_VS1  = YW'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic fs;
    logic ls;
  } ctrl_t;

  logic [DW-1:0]      div_q, div_d;
  logic               tick;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  ctrl_t              ctrl_now;
  ctrl_t              ctrl_src;
  logic               de_q, de_d;
  logic [COLOR_W-1:0] pix_q, pix_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               fs_q, fs_d;
  logic               ls_q, ls_d;

  // Clock-enable divider; with CLK_DIV=1 div_q stays 0 and tick follows en.
  always_comb begin
    tick  = en & (div_q == DIV_LAST);
    div_d = div_q;
    if (en) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_comb begin
    ctrl_now        = '0;
    ctrl_now.active = (x_q < X_ACT) & (y_q < Y_ACT);
    ctrl_now.hs     = (x_q >= X_HS0) & (x_q < X_HS1);
    ctrl_now.vs     = (y_q >= Y_VS0) & (y_q < Y_VS1);
    ctrl_now.fs     = (x_q == '0) & (y_q == '0);
    ctrl_now.ls     = (x_q == '0) & (y_q < Y_ACT);
  end

  // Controls are delayed by PIX_LAT ticks so they meet pixel_in from the
  // external source; a zero-latency build feeds the output stage directly.
  generate
    if (PIX_LAT == 0) begin : g_nolat
      assign ctrl_src = ctrl_now;
    end else begin : g_lat
      localparam int unsigned PL = PIX_LAT;
      ctrl_t pipe_q [PL];
      ctrl_t pipe_d [PL];

      always_comb begin
        pipe_d = pipe_q;
        if (tick) begin
          pipe_d[0] = ctrl_now;
          for (int unsigned i = 1; i < PL; i++) begin
            pipe_d[i] = pipe_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < PL; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign ctrl_src = pipe_q[PL-1];
    end
  endgenerate

  always_comb begin
    de_d  = de_q;
    pix_d = pix_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    fs_d  = 1'b0;
    ls_d  = 1'b0;
    if (tick) begin
      de_d  = ctrl_src.active;
      pix_d = ctrl_src.active ? pixel_in : BLANK_COLOR;
      hs_d  = ctrl_src.hs ? HS_POL : ~HS_POL;
      vs_d  = ctrl_src.vs ? VS_POL : ~VS_POL;
      fs_d  = ctrl_src.fs;
      ls_d  = ctrl_src.ls;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      de_q  <= 1'b0;
      pix_q <= BLANK_COLOR;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      de_q  <= de_d;
      pix_q <= pix_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
      ls_q  <= ls_d;
    end
  end

  assign pos_x       = x_q;
  assign pos_y       = y_q;
  assign req         = ctrl_now.active & en & ~rst;
  assign pixel_out   = pix_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  localparam logic [11:0] BLANK1 = 12'hA5C;
  localparam logic [11:0] BLANK2 = 12'h3F0;
  localparam int FT1 = 14 * 7;
  localparam int FT2 = 12 * 7;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp;
    bit hpol, vpol;
    int lat, div;
  } mode_t;

  typedef struct {
    int x, y;
    bit req, de, hs, vs, fs, ls;
    int p;
  } exp_t;

  typedef struct {
    bit rst, en;
    int clks, x, y;
    bit de, hs, vs, fs;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [11:0] pix1, pix2;
  logic [3:0]  d1_x, d2_x;
  logic [2:0]  d1_y, d2_y;
  logic        d1_req, d1_hs, d1_vs, d1_de, d1_fs, d1_ls;
  logic        d2_req, d2_hs, d2_vs, d2_de, d2_fs, d2_ls;
  logic [11:0] d1_pix, d2_pix;

  int    n_tests = 0;
  int    n_fail  = 0;
  mode_t md1, md2;
  int    e = 0;
  bit    tk1 = 0, tk2 = 0, seen_rst = 0;
  logic [11:0] mem1 [FT1];
  logic [11:0] mem2 [FT2];
  vec_t  tbl [11];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(12), .BLANK_COLOR(BLANK1),
    .PIX_LAT(2), .CLK_DIV(1)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en), .pixel_in(pix1),
    .pos_x(d1_x), .pos_y(d1_y), .req(d1_req), .pixel_out(d1_pix),
    .hsync(d1_hs), .vsync(d1_vs), .de(d1_de),
    .frame_start(d1_fs), .line_start(d1_ls)
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(12), .BLANK_COLOR(BLANK2),
    .PIX_LAT(0), .CLK_DIV(3)
  ) dut2 (
    .clk(clk), .rst(rst), .en(en), .pixel_in(pix2),
    .pos_x(d2_x), .pos_y(d2_y), .req(d2_req), .pixel_out(d2_pix),
    .hsync(d2_hs), .vsync(d2_vs), .de(d2_de),
    .frame_start(d2_fs), .line_start(d2_ls)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: after e enabled clks since reset the block has made n = e/div
  // ticks; counters show raster index n, outputs show index n-(lat+1).
  function automatic exp_t model(input mode_t md, input int ec, input bit ticked,
                                 input bit en_c, input bit rst_c);
    exp_t r;
    int ht, vt, ft, n, pos, m, q, qx, qy;
    ht = md.ha + md.hfp + md.hs + md.hbp;
    vt = md.va + md.vfp + md.vs + md.vbp;
    ft = ht * vt;
    n = ec / md.div;
    pos = n % ft;
    r.x = pos % ht;
    r.y = pos / ht;
    r.req = (r.x < md.ha) && (r.y < md.va) && en_c && !rst_c;
    m = n - (md.lat + 1);
    r.de = 0; r.hs = !md.hpol; r.vs = !md.vpol; r.fs = 0; r.ls = 0; r.p = 0;
    if (m >= 0) begin
      q = m % ft;
      qx = q % ht;
      qy = q / ht;
      r.p = q;
      r.de = (qx < md.ha) && (qy < md.va);
      if (qx >= md.ha + md.hfp && qx < md.ha + md.hfp + md.hs) r.hs = md.hpol;
      if (qy >= md.va + md.vfp && qy < md.va + md.vfp + md.vs) r.vs = md.vpol;
      r.fs = ticked && qx == 0 && qy == 0;
      r.ls = ticked && qx == 0 && qy < md.va;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      e = 0; tk1 = 0; tk2 = 0; seen_rst = 1;
    end else if (en) begin
      e = e + 1;
      tk1 = (e % md1.div) == 0;
      tk2 = (e % md2.div) == 0;
    end else begin
      tk1 = 0; tk2 = 0;
    end
  end

  always @(negedge clk) begin
    exp_t r;
    int k;
    if (seen_rst) begin
      r = model(md1, e, tk1, en, rst);
      cmp("d1.pos_x", d1_x, r.x);
      cmp("d1.pos_y", d1_y, r.y);
      cmp("d1.req", d1_req, r.req);
      cmp("d1.de", d1_de, r.de);
      cmp("d1.hsync", d1_hs, r.hs);
      cmp("d1.vsync", d1_vs, r.vs);
      cmp("d1.frame_start", d1_fs, r.fs);
      cmp("d1.line_start", d1_ls, r.ls);
      cmp("d1.pixel_out", d1_pix, r.de ? mem1[r.p] : BLANK1);
      r = model(md2, e, tk2, en, rst);
      cmp("d2.pos_x", d2_x, r.x);
      cmp("d2.pos_y", d2_y, r.y);
      cmp("d2.req", d2_req, r.req);
      cmp("d2.de", d2_de, r.de);
      cmp("d2.hsync", d2_hs, r.hs);
      cmp("d2.vsync", d2_vs, r.vs);
      cmp("d2.frame_start", d2_fs, r.fs);
      cmp("d2.line_start", d2_ls, r.ls);
      cmp("d2.pixel_out", d2_pix, r.de ? mem2[r.p] : BLANK2);
    end
    // The next load edge takes the pixel for raster index n - lat.
    k = e / md1.div - md1.lat;
    pix1 = (seen_rst && k >= 0) ? mem1[k % FT1] : 12'($urandom);
    k = e / md2.div - md2.lat;
    pix2 = (seen_rst && k >= 0) ? mem2[k % FT2] : 12'($urandom);
  end

  function automatic logic sel_sig(input int sel);
    return (sel == 0) ? d2_hs : d1_vs;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_width(input int sel, input logic lvl, input int bound, output int w);
    int c;
    w = 0; c = 0;
    while (sel_sig(sel) === lvl && c < bound) begin step(); c++; end
    while (sel_sig(sel) !== lvl && c < bound) begin step(); c++; end
    while (sel_sig(sel) === lvl && c < bound) begin step(); c++; w++; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, w;
    bit got;
    md1 = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2, 1};
    md2 = '{6, 2, 3, 1, 3, 1, 2, 1, 1'b0, 1'b0, 0, 3};
    foreach (mem1[i]) mem1[i] = 12'($urandom);
    foreach (mem2[i]) mem2[i] = 12'($urandom);
    rst = 1'b1; en = 1'b0;

    // rst, en, clks, pos_x, pos_y, de, hsync, vsync, frame_start (dut1)
    tbl[0]  = '{1, 0, 2,  0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 3,  3, 0, 1, 0, 0, 1};
    tbl[2]  = '{0, 1, 8,  11, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 2,  13, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 1,  0, 1, 0, 1, 0, 0};
    tbl[5]  = '{0, 1, 1,  1, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 5,  1, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 58, 3, 5, 0, 0, 1, 0};
    tbl[8]  = '{1, 1, 1,  0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 3,  3, 0, 1, 0, 0, 1};
    tbl[10] = '{0, 1, 11, 0, 1, 0, 1, 0, 0};

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst;
      en  = tbl[i].en;
      repeat (tbl[i].clks) step();
      cmp($sformatf("tbl%0d.pos_x", i), d1_x, tbl[i].x);
      cmp($sformatf("tbl%0d.pos_y", i), d1_y, tbl[i].y);
      cmp($sformatf("tbl%0d.de", i), d1_de, tbl[i].de);
      cmp($sformatf("tbl%0d.hsync", i), d1_hs, tbl[i].hs);
      cmp($sformatf("tbl%0d.vsync", i), d1_vs, tbl[i].vs);
      cmp($sformatf("tbl%0d.frame_start", i), d1_fs, tbl[i].fs);
    end

    // Freeze mid-line for 37 clks, then resume with the next pixel.
    rst = 1'b0; en = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      step();
      if ((e / md1.div) % 14 == 5) got = 1;
    end
    cmp("freeze.pre_x", d1_x, 5);
    en = 1'b0;
    repeat (37) step();
    cmp("freeze.hold_x", d1_x, 5);
    cmp("freeze.req", d1_req, 0);
    en = 1'b1;
    step();
    cmp("freeze.resume_x", d1_x, 6);

    // Reset at (6,2), then frame_start must follow PIX_LAT+1 ticks later.
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      step();
      if ((e / md1.div) % FT1 == 2 * 14 + 6) got = 1;
    end
    cmp("rstmid.pre_x", d1_x, 6);
    cmp("rstmid.pre_y", d1_y, 2);
    rst = 1'b1;
    step();
    cmp("rstmid.x", d1_x, 0);
    cmp("rstmid.y", d1_y, 0);
    cmp("rstmid.de", d1_de, 0);
    cmp("rstmid.hsync", d1_hs, 0);
    cmp("rstmid.vsync", d1_vs, 0);
    cmp("rstmid.pixel", d1_pix, BLANK1);
    cmp("rstmid.d2_hsync", d2_hs, 1);
    cmp("rstmid.d2_pixel", d2_pix, BLANK2);
    rst = 1'b0;
    cnt = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      cnt++;
      if (d1_fs === 1'b1) got = 1;
    end
    cmp("rstmid.fs_delay", cnt, 3);

    // Frame periods in clks.
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin step(); if (d1_fs === 1'b1) got = 1; end
    cnt = 0; got = 0;
    for (int c = 0; c < 300 && !got; c++) begin step(); cnt++; if (d1_fs === 1'b1) got = 1; end
    cmp("d1.frame_period", cnt, FT1);
    got = 0;
    for (int c = 0; c < 600 && !got; c++) begin step(); if (d2_fs === 1'b1) got = 1; end
    cnt = 0; got = 0;
    for (int c = 0; c < 600 && !got; c++) begin step(); cnt++; if (d2_fs === 1'b1) got = 1; end
    cmp("d2.frame_period", cnt, FT2 * 3);

    // Sync widths: d2 hsync 3 ticks of 3 clks, d1 vsync one 14-clk line.
    pulse_width(0, 1'b0, 600, w);
    cmp("d2.hsync_width", w, 9);
    pulse_width(1, 1'b1, 600, w);
    cmp("d1.vsync_width", w, 14);

    // Randomised enable gaps and occasional resets, checked every clk.
    for (int c = 0; c < 2500; c++) begin
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; en = 1'b1;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
